// File: rtl/mealy_nonover_pkg.sv
// Shared constants for the non-overlapping Mealy sequence detector.
// Holds the default pattern and the state-index width helper.
package mealy_nonover_pkg;

    localparam int                     DEF_SEQ_LEN = 4;
    localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ     = 4'b1011;

    // Width of a state index S0..S(seq_len-1); never below one bit.
    function automatic int state_w(input int seq_len);
        return (seq_len <= 2) ? 1 : $clog2(seq_len);
    endfunction

endpackage

// File: rtl/mealy_nonover.sv
// Mealy detector for a fixed serial pattern with non-overlapping matches.
// The transition table is derived from SEQ at elaboration time.
module mealy_nonover
    import mealy_nonover_pkg::*;
#(
    parameter int                 SEQ_LEN = DEF_SEQ_LEN,
    parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_x,
    output logic o_seq_detected
);

    localparam int STATE_W = state_w(SEQ_LEN);

    typedef logic [STATE_W-1:0]              state_t;
    typedef logic [SEQ_LEN-1:0][STATE_W-1:0] table_t;

    localparam state_t LAST = state_t'(SEQ_LEN - 1);

    // For every state k and input bit b, find where the FSM goes. A completed
    // match returns to S0; otherwise keep the longest suffix of
    // (prefix_k + b) that is a prefix of SEQ, capped below a full match.
    function automatic table_t build_next(input logic b);
        table_t             tbl;
        logic [SEQ_LEN-1:0] s;
        int                 best;
        int                 max_len;
        bit                 ok;
        tbl = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            s = '0;
            for (int i = 0; i < k; i++)
                s[i] = SEQ[SEQ_LEN-1-i];
            s[k] = b;
            best = 0;
            if (!(k == SEQ_LEN - 1 && b == SEQ[0])) begin
                max_len = (k + 1 < SEQ_LEN) ? k + 1 : k;
                for (int len = 1; len <= max_len; len++) begin
                    ok = 1'b1;
                    for (int i = 0; i < len; i++)
                        if (s[k+1-len+i] != SEQ[SEQ_LEN-1-i])
                            ok = 1'b0;
                    if (ok)
                        best = len;
                end
            end
            tbl[k] = state_t'(best);
        end
        return tbl;
    endfunction

    localparam table_t NEXT_ON_0 = build_next(1'b0);
    localparam table_t NEXT_ON_1 = build_next(1'b1);

    state_t state;
    state_t next_state;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= '0;
        else
            state <= next_state;
    end

    // Unused encodings (non power-of-two SEQ_LEN) fall back to S0.
    always_comb begin
        next_state     = '0;
        o_seq_detected = 1'b0;
        if (state <= LAST)
            next_state = i_x ? NEXT_ON_1[state] : NEXT_ON_0[state];
        if (!i_reset && state == LAST && i_x == SEQ[0])
            o_seq_detected = 1'b1;
    end

endmodule

// File: tb/tb_mealy_nonover.sv
// Directed bench for mealy_nonover with default pattern 1011.
// Inputs change on the falling edge; the Mealy flag is sampled 1 ns later.
module tb_mealy_nonover;

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_x = 1'b0;
    logic o_seq_detected;

    int n_checks = 0;
    int n_pass   = 0;

    mealy_nonover dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_x            (i_x),
        .o_seq_detected (o_seq_detected)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Hold reset for n cycles with i_x = x, flag must stay low throughout.
    task automatic do_reset(input string tag, input int n, input logic x);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            i_reset = 1'b1;
            i_x     = x;
            #1 check($sformatf("%s_rst_det%0d", tag, c), int'(o_seq_detected), 0);
        end
        @(posedge i_clk);
        #1 check($sformatf("%s_rst_state", tag), int'(dut.state), 0);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Drive n bits MSB-first; exp holds the expected flag per bit, same order.
    task automatic run(input string tag, input logic [15:0] bits,
                       input logic [15:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (i != n - 1) @(negedge i_clk);
            i_x = bits[i];
            #1 check($sformatf("%s_bit%0d", tag, n - i), int'(o_seq_detected), int'(exp[i]));
            if (exp[i]) begin
                @(posedge i_clk);
                #1 check($sformatf("%s_s0_after%0d", tag, n - i), int'(dut.state), 0);
            end
        end
    endtask

    initial begin
        do_reset("init", 2, 1'b1);

        run("single",  16'b1011,     16'b0001,     4);
        do_reset("r1", 1, 1'b0);
        run("nonover", 16'b1011011,  16'b0001000,  7);
        do_reset("r2", 1, 1'b0);
        run("b2b",     16'b10111011, 16'b00010001, 8);
        do_reset("r3", 1, 1'b0);
        run("fallbk",  16'b101011,   16'b000001,   6);
        do_reset("r4", 1, 1'b0);
        run("selfloop",16'b11011,    16'b00001,    5);
        do_reset("r5", 1, 1'b0);
        run("zeros",   16'b0000,     16'b0000,     4);

        // Partial 101 then reset while i_x would complete the pattern.
        do_reset("r6", 1, 1'b0);
        run("part",    16'b101,      16'b000,      3);
        do_reset("mid", 1, 1'b1);
        run("after",   16'b1011,     16'b0001,     4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
